// File: rtl/mac_iter_ctrl_pkg.sv
// rtl/mac_iter_ctrl_pkg.sv - shared MAC constants, FSM state, control and flag types
// Contents:
//   MAC_CNT_LEN / MAC_NB_ITER_W / MAC_ADDR_W / MAC_LW : default sizing of the MAC datapath
//   mac_state_e  : iteration controller states
//   mac_ctrl_t   : job configuration latched on start
//   mac_flags_t  : job status seen by the host
//   mac_job_empty: true when a job has nothing to iterate over
package mac_iter_ctrl_pkg;

  localparam int MAC_CNT_LEN   = 1024;
  localparam int MAC_NB_ITER_W = 16;
  localparam int MAC_ADDR_W    = 32;
  localparam int MAC_LW        = $clog2(MAC_CNT_LEN) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    COMPUTE,
    WAIT,
    UPDATEIDX,
    TERMINATE
  } mac_state_e;

  // Struct fields are sized by the package constants, so the controller
  // parameters must keep their package-derived defaults when these are used.
  typedef struct packed {
    logic [MAC_NB_ITER_W-1:0] nb_iter;
    logic [MAC_LW-1:0]        len;
    logic [31:0]              mu;
    logic [MAC_ADDR_W-1:0]    a_base;
    logic [MAC_ADDR_W-1:0]    d_base;
    logic [MAC_ADDR_W-1:0]    a_stride;
    logic [MAC_ADDR_W-1:0]    d_stride;
  } mac_ctrl_t;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic [MAC_NB_ITER_W-1:0] iter_idx;
  } mac_flags_t;

  function automatic logic mac_job_empty(input logic [MAC_NB_ITER_W-1:0] nb_iter,
                                         input logic [MAC_LW-1:0]        len);
    return (nb_iter == '0) || (len == '0);
  endfunction

endpackage

// File: rtl/mac_addr_gen.sv
// rtl/mac_addr_gen.sv - per-iteration base address accumulators for the a and d streams
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset (covers soft clear too)
//   restart_i             : zero both offsets (job accepted)
//   step_i                : advance both offsets by one stride (iteration finished)
//   a_base_i, d_base_i    : latched stream base addresses
//   a_stride_i, d_stride_i: latched per-iteration strides
//   a_addr_o, d_addr_o    : base + idx*stride, built by repeated addition
module mac_addr_gen
  import mac_iter_ctrl_pkg::*;
#(
  parameter int ADDR_W = MAC_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              restart_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] d_base_i,
  input  logic [ADDR_W-1:0] a_stride_i,
  input  logic [ADDR_W-1:0] d_stride_i,
  output logic [ADDR_W-1:0] a_addr_o,
  output logic [ADDR_W-1:0] d_addr_o
);

  logic [ADDR_W-1:0] a_off_q;
  logic [ADDR_W-1:0] d_off_q;

  // Offsets accumulate strides; additions wrap modulo 2^ADDR_W naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      a_off_q <= '0;
      d_off_q <= '0;
    end else if (step_i) begin
      a_off_q <= a_off_q + a_stride_i;
      d_off_q <= d_off_q + d_stride_i;
    end
  end

  assign a_addr_o = a_base_i + a_off_q;
  assign d_addr_o = d_base_i + d_off_q;

endmodule

// File: rtl/mac_iter_ctrl.sv
// rtl/mac_iter_ctrl.sv - MAC iteration controller: sequences streamers and engine over nb_iter passes
// Ports:
//   clk_i, rst_i, clear_i            : clock, synchronous reset, synchronous soft clear
//   start_i + *_i configuration      : job start and its configuration, latched in IDLE
//   a/d_ready_start_i, a/d_done_i    : streamer handshake
//   cnt_out_i                        : engine element counter
//   a/d_req_start_o, a/d_addr_o      : streamer start pulses and per-iteration addresses
//   trans_size_o, eng_*_o            : streamer size and engine control
//   iter_idx_o, busy_o, done_o       : job status
module mac_iter_ctrl
  import mac_iter_ctrl_pkg::*;
#(
  parameter  int CNT_LEN   = MAC_CNT_LEN,
  parameter  int NB_ITER_W = MAC_NB_ITER_W,
  parameter  int ADDR_W    = MAC_ADDR_W,
  localparam int LW        = $clog2(CNT_LEN) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [NB_ITER_W-1:0] nb_iter_i,
  input  logic [LW-1:0]        len_iter_i,
  input  logic [31:0]          mu_i,
  input  logic [ADDR_W-1:0]    a_base_i,
  input  logic [ADDR_W-1:0]    d_base_i,
  input  logic [ADDR_W-1:0]    a_stride_i,
  input  logic [ADDR_W-1:0]    d_stride_i,
  input  logic                 a_ready_start_i,
  input  logic                 d_ready_start_i,
  input  logic                 a_done_i,
  input  logic                 d_done_i,
  input  logic [LW-1:0]        cnt_out_i,
  output logic                 a_req_start_o,
  output logic                 d_req_start_o,
  output logic [ADDR_W-1:0]    a_addr_o,
  output logic [ADDR_W-1:0]    d_addr_o,
  output logic [LW-1:0]        trans_size_o,
  output logic                 eng_clear_o,
  output logic                 eng_enable_o,
  output logic [31:0]          eng_mu_o,
  output logic [LW-1:0]        eng_len_o,
  output logic [NB_ITER_W-1:0] iter_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  mac_state_e           state_q;
  mac_state_e           state_d;
  mac_ctrl_t            ctrl_q;
  mac_flags_t           flags;
  logic [NB_ITER_W-1:0] iter_idx_q;
  logic [NB_ITER_W-1:0] idx_next;
  logic                 a_done_q;
  logic                 d_done_q;
  logic                 soft_rst;
  logic                 accept;
  logic                 fire;
  logic                 step;
  logic                 done_window;

  assign soft_rst    = rst_i || clear_i;
  assign accept      = (state_q == IDLE) && start_i;
  assign idx_next    = iter_idx_q + NB_ITER_W'(1);
  // Done pulses are captured from COMPUTE onwards so an early streamer
  // completion during COMPUTE still releases WAIT later.
  assign done_window = (state_q == COMPUTE) || (state_q == WAIT) ||
                       (state_q == UPDATEIDX) || (state_q == TERMINATE);

  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      iter_idx_q <= '0;
      a_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        ctrl_q.nb_iter  <= nb_iter_i;
        ctrl_q.len      <= len_iter_i;
        ctrl_q.mu       <= mu_i;
        ctrl_q.a_base   <= a_base_i;
        ctrl_q.d_base   <= d_base_i;
        ctrl_q.a_stride <= a_stride_i;
        ctrl_q.d_stride <= d_stride_i;
        iter_idx_q      <= '0;
      end else if (step) begin
        iter_idx_q <= idx_next;
      end

      if (fire) begin
        a_done_q <= 1'b0;
        d_done_q <= 1'b0;
      end else if (done_window) begin
        if (a_done_i) a_done_q <= 1'b1;
        if (d_done_i) d_done_q <= 1'b1;
      end
    end
  end

  // Only the ready flags reach the request outputs combinationally.
  always_comb begin
    state_d      = state_q;
    fire         = 1'b0;
    step         = 1'b0;
    eng_enable_o = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = mac_job_empty(nb_iter_i, len_iter_i) ? TERMINATE : START;
        end
      end
      START: begin
        if (a_ready_start_i && d_ready_start_i) begin
          fire    = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        eng_enable_o = 1'b1;
        if (cnt_out_i == ctrl_q.len) state_d = WAIT;
      end
      WAIT: begin
        if (a_done_q && d_done_q) state_d = UPDATEIDX;
      end
      UPDATEIDX: begin
        step    = 1'b1;
        state_d = (idx_next == ctrl_q.nb_iter) ? TERMINATE : START;
      end
      TERMINATE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flags          = '0;
    flags.busy     = (state_q != IDLE);
    flags.done     = done_o;
    flags.iter_idx = iter_idx_q;
  end

  mac_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (soft_rst),
    .restart_i (accept),
    .step_i    (step),
    .a_base_i  (ctrl_q.a_base),
    .d_base_i  (ctrl_q.d_base),
    .a_stride_i(ctrl_q.a_stride),
    .d_stride_i(ctrl_q.d_stride),
    .a_addr_o  (a_addr_o),
    .d_addr_o  (d_addr_o)
  );

  assign a_req_start_o = fire;
  assign d_req_start_o = fire;
  assign eng_clear_o   = fire;
  assign trans_size_o  = ctrl_q.len;
  assign eng_len_o     = ctrl_q.len;
  assign eng_mu_o      = ctrl_q.mu;
  assign iter_idx_o    = flags.iter_idx;
  assign busy_o        = flags.busy;

endmodule

// File: tb/tb_mac_iter_ctrl.sv
// tb/tb_mac_iter_ctrl.sv - scoreboard bench for mac_iter_ctrl
module tb_mac_iter_ctrl;

  localparam int CNT_LEN   = 1024;
  localparam int NB_ITER_W = 16;
  localparam int ADDR_W    = 32;
  localparam int LW        = $clog2(CNT_LEN) + 1;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 clear_i;
  logic                 start_i;
  logic [NB_ITER_W-1:0] nb_iter_i;
  logic [LW-1:0]        len_iter_i;
  logic [31:0]          mu_i;
  logic [ADDR_W-1:0]    a_base_i, d_base_i, a_stride_i, d_stride_i;
  logic                 a_ready_start_i, d_ready_start_i;
  logic                 a_done_i, d_done_i;
  logic [LW-1:0]        cnt_out_i;
  logic                 a_req_start_o, d_req_start_o;
  logic [ADDR_W-1:0]    a_addr_o, d_addr_o;
  logic [LW-1:0]        trans_size_o;
  logic                 eng_clear_o, eng_enable_o;
  logic [31:0]          eng_mu_o;
  logic [LW-1:0]        eng_len_o;
  logic [NB_ITER_W-1:0] iter_idx_o;
  logic                 busy_o, done_o;

  mac_iter_ctrl #(
    .CNT_LEN(CNT_LEN), .NB_ITER_W(NB_ITER_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .nb_iter_i(nb_iter_i), .len_iter_i(len_iter_i), .mu_i(mu_i),
    .a_base_i(a_base_i), .d_base_i(d_base_i),
    .a_stride_i(a_stride_i), .d_stride_i(d_stride_i),
    .a_ready_start_i(a_ready_start_i), .d_ready_start_i(d_ready_start_i),
    .a_done_i(a_done_i), .d_done_i(d_done_i), .cnt_out_i(cnt_out_i),
    .a_req_start_o(a_req_start_o), .d_req_start_o(d_req_start_o),
    .a_addr_o(a_addr_o), .d_addr_o(d_addr_o), .trans_size_o(trans_size_o),
    .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o),
    .eng_mu_o(eng_mu_o), .eng_len_o(eng_len_o),
    .iter_idx_o(iter_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [31:0] a_addr;
    logic [31:0] d_addr;
    int          idx;
    int          en_cnt;
    logic [31:0] mu;
    int          len;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  a_done_at = -1;
  int  d_done_at = -1;
  int  a_stall_until = 0;
  int  a_off_g = 1;
  int  d_off_g = 1;
  int  en_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Engine model: counter cleared by eng_clear_o; cnt_out includes the element of the current cycle.
  logic [LW-1:0] eng_cnt;
  always @(posedge clk_i) begin
    if (rst_i || eng_clear_o) eng_cnt <= '0;
    else if (eng_enable_o)    eng_cnt <= eng_cnt + 1'b1;
  end
  assign cnt_out_i = eng_cnt + {{(LW-1){1'b0}}, eng_enable_o};

  // Streamer model: done pulses at fixed offsets from the request cycle; a-side ready window.
  always @(posedge clk_i) begin
    #1;
    a_done_i        = (cyc == a_done_at);
    d_done_i        = (cyc == d_done_at);
    a_ready_start_i = (cyc >= a_stall_until);
  end

  // Monitor: pops one expected event whenever the DUT presents a request or done pulse.
  ev_t e;
  always @(negedge clk_i) begin
    if (!busy_o) en_cnt = 0;
    else if (eng_enable_o) en_cnt++;
    if (a_req_start_o || d_req_start_o || eng_clear_o || done_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: req=%0b/%0b clr=%0b done=%0b with no event expected (cycle %0d)",
                 a_req_start_o, d_req_start_o, eng_clear_o, done_o, cyc);
      end else begin
        e = q.pop_front();
        if (e.is_done) begin
          chk("done_pulse", done_o, 1);
          chk("done_no_req", {a_req_start_o, d_req_start_o, eng_clear_o}, 0);
          chk("done_cycle", cyc, e.cyc);
          chk("done_iter_idx", iter_idx_o, e.idx);
          chk("enable_cycles", en_cnt, e.en_cnt);
          chk("done_busy", busy_o, 1);
        end else begin
          chk("a_req", a_req_start_o, 1);
          chk("d_req", d_req_start_o, 1);
          chk("eng_clear", eng_clear_o, 1);
          chk("req_cycle", cyc, e.cyc);
          chk("a_addr", a_addr_o, e.a_addr);
          chk("d_addr", d_addr_o, e.d_addr);
          chk("req_iter_idx", iter_idx_o, e.idx);
          chk("eng_len", eng_len_o, e.len);
          chk("trans_size", trans_size_o, e.len);
          chk("eng_mu", eng_mu_o, e.mu);
          a_done_at = cyc + a_off_g;
          d_done_at = cyc + d_off_g;
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_ctl"}, {a_req_start_o, d_req_start_o, eng_clear_o, eng_enable_o}, 0);
    chk({tag, "_idx"}, iter_idx_o, 0);
    chk({tag, "_addr"}, {a_addr_o, d_addr_o}, 0);
    chk({tag, "_cfg"}, {eng_len_o, trans_size_o, eng_mu_o}, 0);
  endtask

  task automatic run_job(input int nb, input int len, input logic [31:0] mu,
                         input logic [31:0] ab, input logic [31:0] a_str,
                         input logic [31:0] db, input logic [31:0] d_str,
                         input int aoff, input int doff, input int stall, input int abort_idx);
    int  s, t, p, off, n_ev;
    bit  empty, hit;
    ev_t ev;
    @(posedge clk_i); #1;
    s     = cyc;
    empty = (nb == 0) || (len == 0);
    off   = (aoff > doff) ? aoff : doff;
    p     = ((len > off) ? len : off) + 3;
    t     = s + 1 + stall;
    a_off_g       = aoff;
    d_off_g       = doff;
    a_stall_until = s + 1 + stall;
    n_ev = empty ? 0 : ((abort_idx < 0) ? nb : abort_idx + 1);
    for (int k = 0; k < n_ev; k++) begin
      ev.is_done = 1'b0;
      ev.cyc     = t + k * p;
      ev.a_addr  = ab + a_str * 32'(k);
      ev.d_addr  = db + d_str * 32'(k);
      ev.idx     = k;
      ev.en_cnt  = 0;
      ev.mu      = mu;
      ev.len     = len;
      q.push_back(ev);
    end
    if (abort_idx < 0) begin
      ev.is_done = 1'b1;
      ev.cyc     = empty ? s + 1 : t + nb * p;
      ev.idx     = empty ? 0 : nb;
      ev.en_cnt  = empty ? 0 : nb * len;
      q.push_back(ev);
    end
    nb_iter_i  = NB_ITER_W'(nb);
    len_iter_i = LW'(len);
    mu_i       = mu;
    a_base_i   = ab;
    a_stride_i = a_str;
    d_base_i   = db;
    d_stride_i = d_str;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    nb_iter_i  = NB_ITER_W'($urandom);
    len_iter_i = LW'($urandom);
    mu_i       = $urandom;
    a_base_i   = $urandom;
    a_stride_i = $urandom;
    d_base_i   = $urandom;
    d_stride_i = $urandom;
    if (!empty) begin
      @(posedge clk_i); #1;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    if (abort_idx >= 0) begin
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
        @(posedge clk_i); #1;
        if (eng_enable_o && iter_idx_o == NB_ITER_W'(abort_idx)) hit = 1'b1;
      end
      chk("abort_point_reached", hit, 1);
      clear_i = 1'b1;
      @(posedge clk_i); #1;
      clear_i   = 1'b0;
      a_done_at = -1;
      d_done_at = -1;
      @(negedge clk_i);
      chk_all_zero("after_clear");
    end else begin
      for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk_i);
      chk("job_drained", q.size(), 0);
      q.delete();
      @(negedge clk_i);
      chk("idle_after_job", busy_o, 0);
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    nb_iter_i = '0; len_iter_i = '0; mu_i = '0;
    a_base_i = '0; d_base_i = '0; a_stride_i = '0; d_stride_i = '0;
    a_ready_start_i = 1'b1; d_ready_start_i = 1'b1;
    a_done_i = 1'b0; d_done_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("reset");

    // single iteration, len 4, streamer done two cycles after cnt reaches 4
    run_job(1, 4, 32'h0000_1234, 32'h1000, 32'h10, 32'h2000, 32'h20, 6, 6, 0, -1);
    // three iterations at minimum period, d address wraps past 2^32
    run_job(3, 5, 32'hCAFE_0001, 32'h100, 32'h40, 32'hFFFF_FFF0, 32'h10, 2, 3, 0, -1);
    // empty jobs
    run_job(0, 4, 32'h1, 32'h0, 32'h4, 32'h0, 32'h4, 1, 1, 0, -1);
    run_job(2, 0, 32'h2, 32'h0, 32'h4, 32'h0, 32'h4, 1, 1, 0, -1);
    // a done inside COMPUTE, d done five cycles after WAIT entry
    run_job(1, 6, 32'h0BAD_F00D, 32'h3000, 32'h8, 32'h4000, 32'h8, 3, 12, 0, -1);
    // a-side not ready for 10 cycles in START
    run_job(2, 3, 32'h5555_AAAA, 32'h500, 32'h100, 32'h600, 32'h200, 1, 1, 10, -1);
    // soft clear during second of four iterations, then a fresh job
    run_job(4, 8, 32'h7777_0000, 32'h800, 32'h80, 32'h900, 32'h90, 2, 2, 0, 1);
    run_job(2, 3, 32'h0000_00FF, 32'hA00, 32'h20, 32'hB00, 32'h30, 1, 2, 0, -1);

    // clear and start in the same cycle: start dropped
    @(posedge clk_i); #1;
    nb_iter_i = 16'd2; len_iter_i = 11'd3; mu_i = 32'h1111_2222;
    start_i = 1'b1; clear_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; clear_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("clear_start");
    repeat (5) @(negedge clk_i);
    chk("clear_start_still_idle", busy_o, 0);

    chk("queue_empty_end", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
